// File: rtl/ring_osc_freq_meter.sv
// Bank of enable-gated inverter rings plus an external bypass source, measured by a
// ripple prescaler, a clk-domain synchroniser and a windowed, saturating edge counter.
module ring_osc_freq_meter #(
   parameter int NUM_RINGS     = 4,
   parameter int STAGES        = 13,
   parameter int PRESCALE_BITS = 4,
   parameter int WINDOW_BITS   = 16,
   parameter int COUNT_WIDTH   = 16,
   localparam int SEL_W        = ($clog2(NUM_RINGS + 1) > 1) ? $clog2(NUM_RINGS + 1) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   ena,
   input  logic                   start,
   input  logic                   ring_en,
   input  logic [SEL_W-1:0]       ring_sel,
   input  logic                   src_ext,
   input  logic                   ext_osc,
   input  logic [WINDOW_BITS-1:0] win_len,
   output logic                   osc_out,
   output logic                   busy,
   output logic                   done,
   output logic [COUNT_WIDTH-1:0] count,
   output logic                   overflow
);

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_MEASURE, ST_DONE} state_e;

   localparam int                     PAD_W     = 1 << SEL_W;
   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

   state_e                 state_q, state_d;
   logic [SEL_W-1:0]       sel_q, sel_d;
   logic                   src_ext_q, src_ext_d;
   logic [WINDOW_BITS-1:0] win_q, win_d;
   logic [WINDOW_BITS-1:0] timer_q, timer_d;
   logic [1:0]             settle_q, settle_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic                   ovf_q, ovf_d;
   logic [2:0]             sync_q, sync_d;
   logic                   edge_p;

   logic [NUM_RINGS-1:0]   ring_out;
   logic [PAD_W-1:0]       ring_pad;
   logic                   src;
   logic [PRESCALE_BITS:0] div_clk;

   // NOTE: each ring is an intentional combinational loop; with en low the NAND pins
   // stage 0 high, so a deselected ring settles to a static value instead of oscillating.
   for (genvar r = 0; r < NUM_RINGS; r++) begin : g_ring
      logic en;
      (* keep = "true", dont_touch = "true" *) logic [STAGES-1:0] stg;

      assign en     = ring_en & (sel_q == SEL_W'(r));
      assign stg[0] = ~(en & stg[STAGES-1]);
      for (genvar s = 1; s < STAGES; s++) begin : g_stage
         assign stg[s] = ~stg[s-1];
      end
      assign ring_out[r] = stg[STAGES-1] & en;
   end

   // Out-of-range selections read the zero padding above the last ring.
   always_comb begin
      ring_pad                = '0;
      ring_pad[NUM_RINGS-1:0] = ring_out;
   end

   assign src     = src_ext_q ? ext_osc : ring_pad[sel_q];
   assign osc_out = src;

   // Ripple prescaler: each stage toggles on the falling edge of the one before it.
   assign div_clk[0] = src;
   for (genvar p = 0; p < PRESCALE_BITS; p++) begin : g_div
      logic div_q, div_d;

      always_comb div_d = ~div_q;

      always_ff @(negedge div_clk[p] or negedge rst_n) begin
         if (!rst_n) div_q <= 1'b0;
         else        div_q <= div_d;
      end

      assign div_clk[p+1] = div_q;
   end

   // Two synchroniser flops, then one edge-detect flop.
   always_comb sync_d = {sync_q[1:0], div_clk[PRESCALE_BITS]};
   assign edge_p = sync_q[1] & ~sync_q[2];

   // NOTE: clocked state uses non-blocking assignments only; all next values come from comb.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         sel_q     <= '0;
         src_ext_q <= 1'b0;
         win_q     <= '0;
         timer_q   <= '0;
         settle_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         sync_q    <= '0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         src_ext_q <= src_ext_d;
         win_q     <= win_d;
         timer_q   <= timer_d;
         settle_q  <= settle_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         sync_q    <= sync_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:    if (ena && start) state_d = ST_SETTLE;
         ST_SETTLE:  if (settle_q == 2'd3) state_d = (win_q == '0) ? ST_DONE : ST_MEASURE;
         ST_MEASURE: if (timer_q == WINDOW_BITS'(1)) state_d = ST_DONE;
         ST_DONE:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // NOTE: every comb output gets a hold default first, so no branch can infer a latch.
   always_comb begin
      sel_d     = sel_q;
      src_ext_d = src_ext_q;
      win_d     = win_q;
      timer_d   = timer_q;
      settle_d  = settle_q;
      count_d   = count_q;
      ovf_d     = ovf_q;
      unique case (state_q)
         ST_IDLE: begin
            sel_d     = ring_sel;
            src_ext_d = src_ext;
            if (ena && start) begin
               win_d    = win_len;
               count_d  = '0;
               ovf_d    = 1'b0;
               settle_d = '0;
            end
         end
         ST_SETTLE: begin
            settle_d = settle_q + 2'd1;
            timer_d  = win_q;
         end
         ST_MEASURE: begin
            timer_d = timer_q - 1'b1;
            if (edge_p) begin
               if (count_q == COUNT_MAX) ovf_d   = 1'b1;
               else                      count_d = count_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      busy = (state_q == ST_SETTLE) || (state_q == ST_MEASURE);
      done = (state_q == ST_DONE);
   end

   assign count    = count_q;
   assign overflow = ovf_q;

endmodule

// File: doc/ring_osc_freq_meter.md
Name: ring_osc_freq_meter

Overview:
- Parametrised ring-oscillator bank with an on-chip frequency meter.
- Builds NUM_RINGS enable-gated inverter rings of STAGES stages each, plus an external bypass source.
- Divides the selected oscillator by a free-running prescaler, synchronises it into clk, and counts its edges over a programmable window.
- Sits behind the tile's dedicated/bidirectional pins as the successor to the single fixed ring oscillator; measurement results are readable without an off-chip counter.

Parameters:
- NUM_RINGS, 4: number of independent rings (>=1).
- STAGES, 13: inverting stages per ring, odd, >=3.
- PRESCALE_BITS, 4: ripple prescaler width; divide ratio 2^PRESCALE_BITS.
- WINDOW_BITS, 16: width of measurement window length.
- COUNT_WIDTH, 16: width of result counter.

Ports:
- clk  input  1  system clock, all control logic.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  tile enable; start ignored when low.
- start  input  1  level; sampled in IDLE, begins a measurement.
- ring_en  input  1  global oscillator enable.
- ring_sel  input  max(1,$clog2(NUM_RINGS+1))  ring index; values >= NUM_RINGS select constant 0.
- src_ext  input  1  1 = measure ext_osc instead of a ring.
- ext_osc  input  1  external/test oscillator.
- win_len  input  WINDOW_BITS  window length in clk cycles.
- osc_out  output  1  selected raw source, for pin observation.
- busy  output  1  high in SETTLE/MEASURE.
- done  output  1  one-cycle pulse on result valid.
- count  output  COUNT_WIDTH  prescaled edge count of last window.
- overflow  output  1  count saturated in last window.

Behaviour:
- Ring i: stage0 = NAND(en_i, feedback), followed by STAGES-1 inverters; en_i = ring_en & (sel_q == i). Only the selected ring oscillates.
- Ring output is gated AND en_i, so a disabled ring drives 0. Ring nets carry keep/dont_touch attributes.
- Source mux: src = src_ext ? ext_osc : ring[sel_q]; osc_out = src.
- sel_q and src_ext are latched from the ports on start acceptance. They hold during busy and track the ports while IDLE.
- Prescaler: PRESCALE_BITS ripple counter clocked by src, asynchronously cleared by rst_n, otherwise free-running. Its phase is arbitrary at start.
- Sync: prescaler MSB passes through 2 clk flops plus 1 edge flop; each rising edge in clk domain produces edge_p.
- Rate limit: f_src / 2^PRESCALE_BITS < f_clk / 2; faster sources are out of spec.
- FSM states IDLE, SETTLE, MEASURE, DONE:
  - IDLE: if ena & start, latch win_len into win_q and clear count/overflow, then go to SETTLE.
  - SETTLE: exactly 4 cycles to flush the synchroniser; edges are ignored. If win_q == 0, go to DONE; else go to MEASURE with timer = win_q.
  - MEASURE: each cycle, count += edge_p, saturating at 2^COUNT_WIDTH-1. A saturating attempt sets overflow. Timer decrements; the cycle where timer == 1 is the last counted cycle, then go to DONE.
  - DONE: done = 1 for one cycle, then IDLE. count/overflow hold until the next accepted start.
- Start latency: start sampled at edge k gives busy = 1 from k+1. done is at k+5+win_q (win_q > 0) or k+5 (win_q == 0).
- start held high re-triggers on the first IDLE cycle after DONE. start while busy is ignored.
- ring_sel, src_ext and win_len changes during busy have no effect.
- Accuracy: count is within ±1 of floor(win_q × f_src / (2^PRESCALE_BITS × f_clk)).
- Reset, including mid-measurement, asynchronously forces:
  - state = IDLE, busy = 0, done = 0, count = 0, overflow = 0
  - sel_q = 0, timer = 0, prescaler = 0, sync flops = 0

Test Plan:
- Reset, then idle 10 cycles -> busy = 0, done = 0, count = 0, overflow = 0, osc_out = 0 with ring_en = 0.
- src_ext = 1, ext_osc at 4× f_clk, win_len = 400, start pulse -> busy for 404 cycles, done pulse at k+405, count in {99, 100, 101}, overflow = 0.
- src_ext = 1, ext_osc at 1× f_clk, win_len = 0 -> done at k+5, count = 0. Then win_len = 1600 -> count in {99, 100, 101}.
- COUNT_WIDTH = 4 build, ext_osc at 4× f_clk, win_len = 400 -> count = 15, overflow = 1. A following run with win_len = 40 -> count in {9, 10, 11}, overflow = 0.
- During MEASURE, toggle start, change ring_sel and win_len, and assert rst_n low for 1 cycle -> immediate busy = 0, count = 0; a fresh start afterwards completes normally.
- src_ext = 0, ring_sel = NUM_RINGS (invalid), ring_en = 1, win_len = 100 -> osc_out = 0, count = 0. Gate-level sim with ring_sel = 1 -> osc_out toggles, count > 0.
